// File: rtl/ctrl_exec_seq_pkg.sv
// Shared types for the ultrasound controller command executor:
// FSM states, error bit positions and the 16-bit word/sequence types.
package ctrl_exec_pkg;

   typedef logic [15:0] word_t;
   typedef logic [15:0] seq_t;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_LEN     = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RDADDR,
      ST_RDLEN,
      ST_HDR,
      ST_PAYLOAD,
      ST_WAIT_RSP,
      ST_RX_DATA,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ctrl_exec_seq_if.sv
// UDP-side header and payload handshakes between the command executor
// (master) and udp_mac_complete (slave).
interface ctrl_exec_seq_if;
   import ctrl_exec_pkg::*;

   logic       tx_hdr_valid;
   logic       tx_hdr_ready;
   seq_t       tx_seq;
   logic [7:0] tx_payload_tdata;
   logic       tx_payload_tvalid;
   logic       tx_payload_tready;
   logic       tx_payload_tlast;

   logic       rx_hdr_valid;
   logic       rx_hdr_ready;
   seq_t       rx_seq;
   logic [7:0] rx_payload_tdata;
   logic       rx_payload_tvalid;
   logic       rx_payload_tready;
   logic       rx_payload_tlast;

   modport master (
      output tx_hdr_valid, tx_seq, tx_payload_tdata, tx_payload_tvalid, tx_payload_tlast,
      input  tx_hdr_ready, tx_payload_tready,
      input  rx_hdr_valid, rx_seq, rx_payload_tdata, rx_payload_tvalid, rx_payload_tlast,
      output rx_hdr_ready, rx_payload_tready
   );

   modport slave (
      input  tx_hdr_valid, tx_seq, tx_payload_tdata, tx_payload_tvalid, tx_payload_tlast,
      output tx_hdr_ready, tx_payload_tready,
      output rx_hdr_valid, rx_seq, rx_payload_tdata, rx_payload_tvalid, rx_payload_tlast,
      input  rx_hdr_ready, rx_payload_tready
   );

endinterface

// File: rtl/ctrl_exec_seq_rx_pack.sv
// Reply byte packer: big-endian byte pairs become words written at k+1,
// an odd trailing byte is zero-padded, and the word count lands at address 0.
module ctrl_exec_rx_pack
   import ctrl_exec_pkg::*;
#(
   parameter int RAM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              we,
   output logic [RAM_AW-1:0] addr,
   output word_t             wdata,
   output logic [RAM_AW-1:0] count,
   output logic              last_seen,
   output logic              fin
);

   localparam logic [RAM_AW-1:0] CNT_MAX = '1;

   logic       phase;
   logic [7:0] hi_byte;
   logic       len_pending;
   word_t      word_c;

   assign word_c = phase ? {hi_byte, in_data} : {in_data, 8'h00};

   // The count write is deferred one cycle so it never collides with the final data word.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         phase       <= 1'b0;
         hi_byte     <= '0;
         len_pending <= 1'b0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         count       <= '0;
         last_seen   <= 1'b0;
         fin         <= 1'b0;
      end else begin
         we  <= 1'b0;
         fin <= 1'b0;
         if (in_valid) begin
            phase <= !phase;
            if (!phase) begin
               hi_byte <= in_data;
            end
            if (phase || in_last) begin
               we    <= (count != CNT_MAX);
               addr  <= count + 1'b1;
               wdata <= word_c;
               if (count != CNT_MAX) begin
                  count <= count + 1'b1;
               end
            end
            if (in_last) begin
               last_seen   <= 1'b1;
               len_pending <= 1'b1;
            end
         end else if (len_pending) begin
            we          <= 1'b1;
            addr        <= '0;
            wdata       <= word_t'(count);
            fin         <= 1'b1;
            len_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ctrl_exec_seq.sv
// Command executor: sends a length-prefixed command block as one UDP payload and
// stores the matching reply. Define CTRL_EXEC_RETRY_EN to retransmit on reply timeout.
module ctrl_exec_seq
   import ctrl_exec_pkg::*;
#(
   parameter int RAM_AW         = 10,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRY      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [RAM_AW-1:0] cmd_ram_addr,
   input  word_t             cmd_ram_rdata,
   output logic [RAM_AW-1:0] rsp_ram_addr,
   output word_t             rsp_ram_wdata,
   output logic              rsp_ram_we,
   ctrl_exec_seq_if.master   udp,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [RAM_AW-1:0] rsp_len
);

   localparam int          TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LEN_MAX = (32'd1 << RAM_AW) - 32'd1;

   state_t            state_q, state_d;
   seq_t              seq_q;
   logic [RAM_AW-1:0] len_q;
   logic [RAM_AW-1:0] word_idx;
   word_t             cur_word;
   logic              byte_sel;
   logic [TMR_W-1:0]  tmr;
   logic              drain;
   logic              can_retry;

   logic tx_byte_fire, last_byte, hdr_fire, seq_match, timeout_now, len_bad;
   logic tx_hdr_valid_c, tx_tvalid_c, rx_hdr_ready_c, rx_tready_c;

   logic              pk_in_valid, pk_we, pk_last_seen, pk_fin;
   logic [RAM_AW-1:0] pk_addr, pk_count;
   word_t             pk_wdata;

   assign tx_byte_fire = (state_q == ST_PAYLOAD) && udp.tx_payload_tready;
   assign last_byte    = byte_sel && (word_idx == len_q);
   assign hdr_fire     = (state_q == ST_WAIT_RSP) && !drain && udp.rx_hdr_valid;
   assign seq_match    = (udp.rx_seq == seq_q);
   assign timeout_now  = (state_q == ST_WAIT_RSP) && (tmr == TMR_W'(TIMEOUT_CYCLES - 1))
                         && !(hdr_fire && seq_match);
   assign len_bad      = {16'h0000, cmd_ram_rdata} > LEN_MAX;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      tx_hdr_valid_c = 1'b0;
      tx_tvalid_c    = 1'b0;
      rx_hdr_ready_c = 1'b0;
      rx_tready_c    = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_d = ST_RDADDR;
         end
         ST_RDADDR: state_d = ST_RDLEN;
         ST_RDLEN:  state_d = len_bad ? ST_DONE : ST_HDR;
         ST_HDR: begin
            tx_hdr_valid_c = 1'b1;
            if (udp.tx_hdr_ready) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            tx_tvalid_c = 1'b1;
            if (tx_byte_fire && last_byte) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            rx_hdr_ready_c = !drain;
            rx_tready_c    = drain;
            if (hdr_fire && seq_match) state_d = ST_RX_DATA;
            else if (timeout_now)      state_d = can_retry ? ST_RDADDR : ST_DONE;
         end
         ST_RX_DATA: begin
            rx_tready_c = !pk_last_seen;
            if (pk_fin) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign udp.tx_hdr_valid      = tx_hdr_valid_c;
   assign udp.tx_seq            = seq_q;
   assign udp.tx_payload_tvalid = tx_tvalid_c;
   assign udp.tx_payload_tdata  = tx_tvalid_c ? (byte_sel ? cur_word[7:0] : cur_word[15:8]) : 8'h00;
   assign udp.tx_payload_tlast  = tx_tvalid_c && last_byte;
   assign udp.rx_hdr_ready      = rx_hdr_ready_c;
   assign udp.rx_payload_tready = rx_tready_c;

   // The read address always points at the next word, so its data is ready before the low byte of the current one leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_q        <= '0;
         err          <= '0;
         rsp_len      <= '0;
         cmd_ram_addr <= '0;
         len_q        <= '0;
         cur_word     <= '0;
         byte_sel     <= 1'b0;
         word_idx     <= '0;
         tmr          <= '0;
         drain        <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start) begin
            seq_q        <= seq_q + 1'b1;
            err          <= '0;
            rsp_len      <= '0;
            cmd_ram_addr <= '0;
         end
         if (state_q == ST_RDLEN) begin
            len_q        <= cmd_ram_rdata[RAM_AW-1:0];
            cur_word     <= cmd_ram_rdata;
            byte_sel     <= 1'b0;
            word_idx     <= '0;
            cmd_ram_addr <= RAM_AW'(1);
            if (len_bad) err[ERR_LEN] <= 1'b1;
         end
         if (tx_byte_fire) begin
            byte_sel <= !byte_sel;
            if (byte_sel) begin
               cur_word     <= cmd_ram_rdata;
               word_idx     <= word_idx + 1'b1;
               cmd_ram_addr <= cmd_ram_addr + 1'b1;
            end
         end
         if (timeout_now) begin
            if (can_retry) cmd_ram_addr <= '0;
            else           err[ERR_TIMEOUT] <= 1'b1;
         end
         tmr <= (state_q == ST_WAIT_RSP) ? tmr + 1'b1 : '0;
         if (state_q != ST_WAIT_RSP) begin
            drain <= 1'b0;
         end else if (drain) begin
            if (udp.rx_payload_tvalid && udp.rx_payload_tlast) drain <= 1'b0;
         end else if (hdr_fire && !seq_match) begin
            drain <= 1'b1;
         end
         if (pk_fin) rsp_len <= pk_count;
      end
   end

`ifdef CTRL_EXEC_RETRY_EN
   localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RC_W-1:0] retry_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         retry_cnt <= '0;
      end else if (state_q == ST_IDLE && start) begin
         retry_cnt <= '0;
      end else if (timeout_now && can_retry) begin
         retry_cnt <= retry_cnt + 1'b1;
      end
   end

   assign can_retry = int'(retry_cnt) < MAX_RETRY;
`else
   // Retransmission is absent in this build; MAX_RETRY is never negative.
   assign can_retry = (MAX_RETRY < 0);
`endif

   assign pk_in_valid = (state_q == ST_RX_DATA) && udp.rx_payload_tvalid && !pk_last_seen;

   ctrl_exec_rx_pack #(.RAM_AW(RAM_AW)) u_rx_pack (
      .clk       (clk),
      .rst       (rst),
      .clear     (state_q != ST_RX_DATA),
      .in_valid  (pk_in_valid),
      .in_data   (udp.rx_payload_tdata),
      .in_last   (udp.rx_payload_tlast),
      .we        (pk_we),
      .addr      (pk_addr),
      .wdata     (pk_wdata),
      .count     (pk_count),
      .last_seen (pk_last_seen),
      .fin       (pk_fin)
   );

   assign rsp_ram_we    = pk_we;
   assign rsp_ram_addr  = pk_addr;
   assign rsp_ram_wdata = pk_wdata;

endmodule

// File: tb/tb_ctrl_exec_seq.sv
// Directed bench for ctrl_exec_seq with RAM models and a UDP loopback partner;
// expectations adapt to whether CTRL_EXEC_RETRY_EN is defined.
module tb_ctrl_exec_seq;

   localparam int AW = 4;
`ifdef CTRL_EXEC_RETRY_EN
   localparam int EXP_TX = 3;
`else
   localparam int EXP_TX = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] cmd_ram_addr, rsp_ram_addr, rsp_len;
   logic [15:0]   cmd_ram_rdata, rsp_ram_wdata;
   logic          rsp_ram_we, busy, done;
   logic [1:0]    err;

   logic [15:0] cmd_mem [16];
   logic [15:0] rsp_mem [16];
   logic [7:0]  rx_bytes [16];
   logic [7:0]  exp_tx [8];
   logic [8:0]  tx_q [$];
   int          hdr_q [$];
   int          tlast_q [$];
   int          cyc = 0;
   int          done_cyc = 0;
   int          rsp_wr_count = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        bp_mode;
   logic [15:0] exp_seq;

   ctrl_exec_seq_if udp ();

   ctrl_exec_seq #(.RAM_AW(AW), .TIMEOUT_CYCLES(100), .MAX_RETRY(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cmd_ram_addr  (cmd_ram_addr),
      .cmd_ram_rdata (cmd_ram_rdata),
      .rsp_ram_addr  (rsp_ram_addr),
      .rsp_ram_wdata (rsp_ram_wdata),
      .rsp_ram_we    (rsp_ram_we),
      .udp           (udp),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .rsp_len       (rsp_len)
   );

   always #5 clk = ~clk;

   // RAM models and transaction logging, all sampled on the active edge.
   always @(posedge clk) begin
      cyc           <= cyc + 1;
      cmd_ram_rdata <= cmd_mem[cmd_ram_addr];
      if (rsp_ram_we) begin
         rsp_mem[rsp_ram_addr] <= rsp_ram_wdata;
         rsp_wr_count          <= rsp_wr_count + 1;
      end
      if (udp.tx_payload_tvalid && udp.tx_payload_tready) begin
         tx_q.push_back({udp.tx_payload_tlast, udp.tx_payload_tdata});
         if (udp.tx_payload_tlast) tlast_q.push_back(cyc);
      end
      if (udp.tx_hdr_valid && udp.tx_hdr_ready) hdr_q.push_back(cyc);
      if (done) done_cyc <= cyc;
   end

   always @(negedge clk) udp.tx_payload_tready = bp_mode ? !udp.tx_payload_tready : 1'b1;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_seq = exp_seq + 16'd1;
   endtask

   task automatic sendReply(input logic [15:0] seq, input int n);
      int guard;
      @(negedge clk);
      udp.rx_hdr_valid = 1'b1;
      udp.rx_seq       = seq;
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (!udp.rx_hdr_ready && guard < 500);
      checkOutput("rx_hdr_accepted", 64'(udp.rx_hdr_ready), 64'd1);
      @(negedge clk);
      udp.rx_hdr_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         udp.rx_payload_tvalid = 1'b1;
         udp.rx_payload_tdata  = rx_bytes[i];
         udp.rx_payload_tlast  = (i == n - 1);
         guard = 0;
         do begin
            @(posedge clk);
            guard++;
         end while (!udp.rx_payload_tready && guard < 500);
         if (guard >= 500) checkOutput("rx_byte_accepted", 64'd0, 64'd1);
         @(negedge clk);
      end
      udp.rx_payload_tvalid = 1'b0;
      udp.rx_payload_tlast  = 1'b0;
   endtask

   task automatic waitDone(input int max_cycles);
      int  n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < max_cycles) begin
         @(posedge clk);
         n++;
         if (done) seen = 1'b1;
      end
      checkOutput("done_seen", 64'(seen), 64'd1);
      @(negedge clk);
   endtask

   task automatic checkTx(input string name, input int base);
      checkOutput({name, "_count"}, 64'(tx_q.size() - base), 64'd8);
      for (int i = 0; i < 8; i++) begin
         logic [8:0] obs;
         obs = (base + i < tx_q.size()) ? tx_q[base + i] : 9'h1FF;
         checkOutput($sformatf("%s_byte%0d", name, i), 64'(obs), 64'({i == 7, exp_tx[i]}));
      end
   endtask

   task automatic loadEcho();
      for (int i = 0; i < 8; i++) rx_bytes[i] = exp_tx[i];
   endtask

   initial begin
      int base, hb, lb, wb;
      rst = 1'b1;
      start = 1'b0;
      bp_mode = 1'b0;
      exp_seq = 16'd0;
      udp.tx_hdr_ready      = 1'b1;
      udp.rx_hdr_valid      = 1'b0;
      udp.rx_seq            = 16'd0;
      udp.rx_payload_tvalid = 1'b0;
      udp.rx_payload_tdata  = 8'h00;
      udp.rx_payload_tlast  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cmd_mem[i] = 16'h0000;
         rsp_mem[i] = 16'hDEAD;
      end
      cmd_mem[0] = 16'h0003; cmd_mem[1] = 16'h1122;
      cmd_mem[2] = 16'h3344; cmd_mem[3] = 16'h5566;
      exp_tx = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_seq", 64'(udp.tx_seq), 64'd0);
      checkOutput("rst_hdr_valid", 64'(udp.tx_hdr_valid), 64'd0);

      $display("[TB] basic loopback");
      base = tx_q.size();
      applyStimulus();
      loadEcho();
      sendReply(exp_seq, 8);
      waitDone(200);
      checkTx("basic", base);
      checkOutput("basic_seq", 64'(udp.tx_seq), 64'd1);
      checkOutput("basic_ram0", 64'(rsp_mem[0]), 64'h0004);
      checkOutput("basic_ram1", 64'(rsp_mem[1]), 64'h0003);
      checkOutput("basic_ram2", 64'(rsp_mem[2]), 64'h1122);
      checkOutput("basic_ram3", 64'(rsp_mem[3]), 64'h3344);
      checkOutput("basic_ram4", 64'(rsp_mem[4]), 64'h5566);
      checkOutput("basic_len", 64'(rsp_len), 64'd4);
      checkOutput("basic_err", 64'(err), 64'd0);
      checkOutput("basic_busy", 64'(busy), 64'd0);

      $display("[TB] tx backpressure");
      bp_mode = 1'b1;
      base = tx_q.size();
      applyStimulus();
      sendReply(exp_seq, 8);
      waitDone(200);
      bp_mode = 1'b0;
      checkTx("bp", base);
      checkOutput("bp_seq", 64'(udp.tx_seq), 64'd2);

      $display("[TB] odd reply");
      applyStimulus();
      rx_bytes[0] = 8'hAA; rx_bytes[1] = 8'hBB; rx_bytes[2] = 8'hCC;
      sendReply(exp_seq, 3);
      waitDone(200);
      checkOutput("odd_ram1", 64'(rsp_mem[1]), 64'hAABB);
      checkOutput("odd_ram2", 64'(rsp_mem[2]), 64'hCC00);
      checkOutput("odd_ram0", 64'(rsp_mem[0]), 64'h0002);
      checkOutput("odd_len", 64'(rsp_len), 64'd2);

      $display("[TB] sequence filter");
      applyStimulus();
      wb = rsp_wr_count;
      rx_bytes[0] = 8'h99; rx_bytes[1] = 8'h88; rx_bytes[2] = 8'h77; rx_bytes[3] = 8'h66;
      sendReply(exp_seq + 16'd1, 4);
      repeat (2) @(negedge clk);
      checkOutput("filter_no_writes", 64'(rsp_wr_count - wb), 64'd0);
      checkOutput("filter_busy", 64'(busy), 64'd1);
      rx_bytes[0] = 8'hDE; rx_bytes[1] = 8'hAD; rx_bytes[2] = 8'hBE; rx_bytes[3] = 8'hEF;
      sendReply(exp_seq, 4);
      waitDone(200);
      checkOutput("filter_ram1", 64'(rsp_mem[1]), 64'hDEAD);
      checkOutput("filter_ram2", 64'(rsp_mem[2]), 64'hBEEF);
      checkOutput("filter_writes", 64'(rsp_wr_count - wb), 64'd3);
      checkOutput("filter_len", 64'(rsp_len), 64'd2);

      $display("[TB] length overflow");
      cmd_mem[0] = 16'h0010;
      hb = hdr_q.size();
      applyStimulus();
      waitDone(50);
      checkOutput("ovf_err", 64'(err), 64'h2);
      checkOutput("ovf_no_hdr", 64'(hdr_q.size() - hb), 64'd0);
      cmd_mem[0] = 16'h0003;

      $display("[TB] reply timeout");
      hb = hdr_q.size();
      lb = tlast_q.size();
      applyStimulus();
      waitDone(2000);
      checkOutput("tmo_tx_count", 64'(hdr_q.size() - hb), 64'(EXP_TX));
      checkOutput("tmo_err", 64'(err), 64'h1);
      checkOutput("tmo_done_gap", 64'(done_cyc - tlast_q[tlast_q.size() - 1]), 64'd101);
`ifdef CTRL_EXEC_RETRY_EN
      if (hdr_q.size() - hb >= 2)
         checkOutput("tmo_retry_gap", 64'(hdr_q[hb + 1] - tlast_q[lb]), 64'd103);
      else
         checkOutput("tmo_retry_gap", 64'd0, 64'd103);
`endif

      $display("[TB] reset during payload");
      applyStimulus();
      begin
         int guard;
         guard = 0;
         while (!udp.tx_payload_tvalid && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("mid_payload_reached", 64'(udp.tx_payload_tvalid), 64'd1);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_tvalid", 64'(udp.tx_payload_tvalid), 64'd0);
      checkOutput("mid_rst_seq", 64'(udp.tx_seq), 64'd0);
      checkOutput("mid_rst_addr", 64'(cmd_ram_addr), 64'd0);
      checkOutput("mid_rst_err", 64'(err), 64'd0);
      checkOutput("mid_rst_len", 64'(rsp_len), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
